// File: rtl/load_store_unit.sv
// Data-memory load/store sequencer: word-aligned accesses, sub-word
// extraction on loads and read-modify-write merging on sub-word stores.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err,
  output logic                  o_dmem_cen,
  output logic                  o_dmem_wen,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  input  logic                  i_dmem_stall
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RDW  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_WRW  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]            state_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wd_q;
  logic [DATA_WIDTH-1:0] mwd_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  req_err;
  logic [1:0]            lane;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [DATA_WIDTH-1:0] ld_val;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    req_err = 1'b1;
    unique case (i_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = i_addr[0];
      3'b010:  req_err = |i_addr[1:0];
      3'b100:  req_err = i_we;
      3'b101:  req_err = i_we | i_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  assign lane   = addr_q[1:0];
  assign byte_v = i_dmem_rdata[{lane, 3'b000} +: 8];
  assign half_v = i_dmem_rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = i_dmem_rdata;
    unique case (f3_q)
      3'b000:  ld_val = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      3'b100:  ld_val = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      3'b001:  ld_val = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      3'b101:  ld_val = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: ld_val = i_dmem_rdata;
    endcase
  end

  // Only the addressed lane of the fetched word is replaced.
  always_comb begin
    merged = i_dmem_rdata;
    if (f3_q[1:0] == 2'b00)
      merged[{lane, 3'b000} +: 8] = wd_q[7:0];
    else if (f3_q[1:0] == 2'b01)
      merged[{lane[1], 4'b0000} +: 16] = wd_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wd_q    <= '0;
      mwd_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_req) begin
          we_q   <= i_we;
          f3_q   <= i_funct3;
          addr_q <= i_addr;
          wd_q   <= i_wdata[15:0];
          mwd_q  <= i_wdata;
          err_q  <= req_err;
          if (req_err)
            state_q <= S_DONE;
          else if (i_we && i_funct3[1:0] == 2'b10)
            state_q <= S_WR;
          else
            state_q <= S_RD;
        end
        S_RD:  state_q <= S_RDW;
        S_RDW: if (!i_dmem_stall) begin
          if (we_q) begin
            mwd_q   <= merged;
            state_q <= S_WR;
          end else begin
            rdata_q <= ld_val;
            state_q <= S_DONE;
          end
        end
        S_WR:  state_q <= S_WRW;
        S_WRW: if (!i_dmem_stall) state_q <= S_DONE;
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = state_q != S_IDLE;
  assign o_done       = state_q == S_DONE;
  assign o_err        = o_done & err_q;
  assign o_rdata      = rdata_q;
  assign o_dmem_cen   = (state_q == S_RD) | (state_q == S_WR);
  assign o_dmem_wen   = state_q == S_WR;
  assign o_dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign o_dmem_wdata = mwd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: stalling word memory plus a reference
// model built from byte-lane arithmetic on a shadow memory.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_busy, o_done, o_err, o_dmem_cen, o_dmem_wen;
  logic [31:0] o_rdata, o_dmem_addr, o_dmem_wdata;
  logic [31:0] i_dmem_rdata;
  logic        i_dmem_stall;

  always #5 i_clk = ~i_clk;

  load_store_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
    .o_dmem_cen(o_dmem_cen), .o_dmem_wen(o_dmem_wen),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_stall(i_dmem_stall)
  );

  // Memory: stall for a configured count after each access; writes
  // commit only when the access completes, so a reset abandons them.
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int          rs_cfg = 0, ws_cfg = 0, cnt = 0;
  logic        pend_w = 1'b0;
  logic [3:0]  pend_idx = '0, rd_idx = '0;
  logic [31:0] pend_data = '0;
  logic        pl_we = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  assign i_dmem_stall = cnt > 0;
  assign i_dmem_rdata = mem[rd_idx];

  always @(posedge i_clk) begin
    if (pl_we) mem[pl_idx] <= pl_val;
    if (!i_rst_n) begin
      cnt    <= 0;
      pend_w <= 1'b0;
    end else if (o_dmem_cen) begin
      cnt <= o_dmem_wen ? ws_cfg : rs_cfg;
      if (o_dmem_wen) begin
        pend_w    <= 1'b1;
        pend_idx  <= o_dmem_addr[5:2];
        pend_data <= o_dmem_wdata;
      end else begin
        rd_idx <= o_dmem_addr[5:2];
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end else if (pend_w) begin
      mem[pend_idx] <= pend_data;
      pend_w        <= 1'b0;
    end
  end

  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit ref_err(bit we, logic [2:0] f, logic [31:0] a);
    if (f == 3'd0) return 1'b0;
    if (f == 3'd1) return a % 2 != 0;
    if (f == 3'd2) return a % 4 != 0;
    if (f == 3'd4) return we;
    if (f == 3'd5) return we || (a % 2 != 0);
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] f,
                                          logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    if (f == 3'd0) return b >= 128 ? b - 32'd256 : b;
    if (f == 3'd1) return h >= 32768 ? h - 32'd65536 : h;
    if (f == 3'd4) return b;
    if (f == 3'd5) return h;
    return w;
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] w, logic [2:0] f,
                                           logic [31:0] a, logic [31:0] d);
    logic [31:0] m;
    int          sh;
    if (f == 3'd2) return d;
    sh = (f == 3'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
    m = ((f == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~m) | ((d << sh) & m);
  endfunction

  task automatic setw(input int i, input logic [31:0] v);
    @(negedge i_clk);
    pl_we  = 1'b1;
    pl_idx = i[3:0];
    pl_val = v;
    @(posedge i_clk);
    #1 pl_we = 1'b0;
    ref_mem[i] = v;
  endtask

  task automatic run_req(input bit we, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         input int rs, input int ws,
                         input bit toggle, input bit hold);
    bit          e, rmw, wseen;
    int          lat, xlat, ncen, xcen, busybad, idx;
    logic [31:0] waddr, wdat, raddr, xw, grd;
    logic        gerr;
    e = ref_err(we, f, a);
    rmw = we && f != 3'd2;
    idx = int'(a[5:2]);
    xlat = e ? 1 : rmw ? 5 + rs + ws : we ? 3 + ws : 3 + rs;
    xcen = e ? 0 : rmw ? 2 : 1;
    xw = ref_store(ref_mem[idx], f, a, d);
    rs_cfg = rs;
    ws_cfg = ws;
    lat = 0; ncen = 0; busybad = 0; wseen = 0;
    waddr = '0; wdat = '0; raddr = '0; gerr = 1'b0; grd = '0;
    @(negedge i_clk);
    i_req = 1'b1; i_we = we; i_funct3 = f; i_addr = a; i_wdata = d;
    @(posedge i_clk);
    #1 if (!hold) i_req = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge i_clk);
      if (!o_busy) busybad++;
      if (o_dmem_cen) begin
        ncen++;
        if (o_dmem_wen) begin
          wseen = 1; waddr = o_dmem_addr; wdat = o_dmem_wdata;
        end else raddr = o_dmem_addr;
      end
      if (o_done) begin
        lat = k; gerr = o_err; grd = o_rdata;
        break;
      end
      if (toggle) begin
        i_req = 1'($urandom); i_we = 1'($urandom);
        i_funct3 = 3'($urandom); i_addr = $urandom; i_wdata = $urandom;
      end
    end
    if (!hold) i_req = 1'b0;
    if (!e && !we) exp_rdata = ref_load(ref_mem[idx], f, a);
    if (!e && we) ref_mem[idx] = xw;
    check("latency", lat, xlat);
    check("err", {31'd0, gerr}, {31'd0, e});
    check("rdata", grd, exp_rdata);
    check("cen_count", ncen, xcen);
    check("busy_during", busybad, 0);
    if (!e && (!we || rmw)) check("rd_addr", raddr, a & ~32'd3);
    if (!e && we) begin
      check("wr_seen", {31'd0, wseen}, 32'd1);
      check("wr_addr", waddr, a & ~32'd3);
      check("wr_data", wdat, xw);
      check("mem_word", mem[idx], ref_mem[idx]);
    end
  endtask

  task automatic idle_chk(input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      if (o_busy || o_done || o_dmem_cen) bad++;
    end
    check("idle_quiet", bad, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, o_done}, 32'd0);
    check({tag, "_err"}, {31'd0, o_err}, 32'd0);
    check({tag, "_cen"}, {31'd0, o_dmem_cen}, 32'd0);
    check({tag, "_wen"}, {31'd0, o_dmem_wen}, 32'd0);
    check({tag, "_rdata"}, o_rdata, 32'd0);
    check({tag, "_addr"}, o_dmem_addr, 32'd0);
    check({tag, "_wdata"}, o_dmem_wdata, 32'd0);
  endtask

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    repeat (3) @(negedge i_clk);
    chk_reset_outs("reset");
    i_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) setw(i, $urandom);

    setw(4, 32'h8765_4321);
    run_req(0, 3'd2, 32'h10, 0, 0, 0, 0, 0);
    check("lw_const", o_rdata, 32'h8765_4321);
    setw(4, 32'h80FF_0000);
    run_req(0, 3'd0, 32'h13, 0, 0, 0, 0, 0);
    check("lb_const", o_rdata, 32'hFFFF_FF80);
    run_req(0, 3'd4, 32'h13, 0, 1, 0, 0, 0);
    check("lbu_const", o_rdata, 32'h0000_0080);
    run_req(0, 3'd1, 32'h12, 0, 0, 0, 0, 0);
    check("lh_const", o_rdata, 32'hFFFF_80FF);
    run_req(0, 3'd5, 32'h12, 0, 0, 0, 0, 0);
    check("lhu_const", o_rdata, 32'h0000_80FF);

    setw(8, 32'h1122_3344);
    run_req(1, 3'd0, 32'h21, 32'hAB, 2, 0, 0, 0);
    check("sb_const", mem[8], 32'h1122_AB44);

    run_req(0, 3'd2, 32'h02, 0, 0, 0, 0, 0);
    run_req(1, 3'd1, 32'h05, 32'h1234, 0, 0, 0, 0);
    run_req(0, 3'd3, 32'h10, 0, 0, 0, 0, 0);
    run_req(1, 3'd4, 32'h10, 32'h55, 0, 0, 0, 0);
    check("err_rdata_hold", o_rdata, 32'h0000_80FF);

    // Reset lands while the sub-word write is still stalled.
    setw(8, 32'h1122_3344);
    rs_cfg = 0; ws_cfg = 5;
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'd1;
    i_addr = 32'h22; i_wdata = 32'hBEEF;
    @(posedge i_clk);
    #1 i_req = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk_reset_outs("rmw_reset");
    i_rst_n = 1'b1;
    exp_rdata = '0;
    run_req(0, 3'd2, 32'h20, 0, 0, 0, 0, 0);
    check("rmw_no_write", o_rdata, 32'h1122_3344);

    @(negedge i_clk);
    i_rst_n = 1'b0; i_req = 1'b1; i_we = 1'b0;
    i_funct3 = 3'd2; i_addr = 32'h10;
    @(negedge i_clk);
    i_rst_n = 1'b1; i_req = 1'b0;
    exp_rdata = '0;
    idle_chk(2);

    run_req(0, 3'd0, 32'h31, 0, 2, 0, 1, 0);
    idle_chk(3);

    run_req(0, 3'd2, 32'h1C, 0, 0, 0, 0, 1);
    run_req(0, 3'd5, 32'h2A, 0, 1, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_req(1'($urandom), f3s[$urandom_range(0, 7)],
              32'($urandom_range(0, 63)), $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2),
              1'($urandom), 1'b0);
    end
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access sequencer sitting between the core's execute stage and the word-organised data memory. It accepts one load or store request at a time and issues word-aligned memory reads and writes. It performs byte/half-word extraction with sign/zero extension for loads, and read-modify-write merging for sub-word stores. It returns the load result, or an error flag, with a one-cycle done pulse that the core uses to enable its operand/write-back registers.

## Interface

- DATA_WIDTH, 32, data path width (fixed at 32; byte lanes assume 4 bytes)
- ADDR_WIDTH, 32, byte address width

- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  request strobe; sampled only in IDLE
- i_we  in  1  1 = store, 0 = load
- i_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  ADDR_WIDTH  byte address
- i_wdata  in  DATA_WIDTH  store data, right-aligned
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  DATA_WIDTH  extended load result; held until next o_done
- o_err  out  1  valid with o_done: misaligned or illegal access
- o_dmem_cen  out  1  memory request, one-cycle pulse
- o_dmem_wen  out  1  write qualifier for o_dmem_cen
- o_dmem_addr  out  ADDR_WIDTH  {addr[ADDR_WIDTH-1:2], 2'b00}
- o_dmem_wdata  out  DATA_WIDTH  full word to write
- i_dmem_rdata  in  DATA_WIDTH  read word, valid in the cycle stall is low in RD_WAIT
- i_dmem_stall  in  1  memory not ready

## Operation

- Request capture: in IDLE with i_req=1, register i_we, i_funct3, i_addr and i_wdata. Later changes on these inputs are ignored until the next IDLE. i_req outside IDLE is ignored.
- Error check happens at capture. The request is an error if any of the following holds:
  - H/HU with addr[0]=1
  - W with addr[1:0]≠00
  - funct3 ∈ {011, 110, 111}
  - store with funct3 100/101

  An erroring request goes IDLE→DONE with o_err=1, makes no memory access, and leaves o_rdata unchanged.
- FSM states: IDLE, RD, RD_WAIT, WR, WR_WAIT, DONE.
  - Load: IDLE→RD→RD_WAIT→DONE→IDLE.
  - SW: IDLE→WR→WR_WAIT→DONE→IDLE.
  - SB/SH (read-modify-write): IDLE→RD→RD_WAIT→WR→WR_WAIT→DONE→IDLE.
- RD: o_dmem_cen=1, o_dmem_wen=0 for exactly one cycle.
- WR: o_dmem_cen=1, o_dmem_wen=1 for exactly one cycle.
- *_WAIT: stay while i_dmem_stall=1. On stall=0, advance; in RD_WAIT, capture i_dmem_rdata into the internal word register.
- Load extraction uses lane = addr[1:0]:
  - B/BU selects byte lane.
  - H/HU selects half addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - o_rdata updates on entry to DONE.
- Store merge replaces only the addressed byte/half of the captured word with i_wdata[7:0] or [15:0]. SW writes i_wdata unmodified.
- DONE: o_done=1, o_err valid, o_rdata valid. For stores, o_rdata holds its previous value. Always return to IDLE next cycle.
- Reset (i_rst_n=0 at a clock edge), from any state including mid-RMW:
  - state→IDLE
  - o_done, o_err, o_dmem_cen, o_dmem_wen = 0
  - o_rdata, o_dmem_addr, o_dmem_wdata = 0

  An interrupted RMW performs no write.

## Timing

- Cycle 0 is the edge sampling i_req in IDLE.
- Load, no stall: cen high in cycle 1 (RD), data sampled in cycle 2 (RD_WAIT), o_done in cycle 3. Latency is 3 cycles; each stall cycle adds 1.
- SW, no stall: cen/wen in cycle 1, o_done in cycle 3.
- SB/SH, no stall: read cen in cycle 1, write cen in cycle 3, o_done in cycle 5.
- Error request: o_done+o_err in cycle 1.
- o_busy rises in cycle 1 and falls in the cycle after DONE. A new request is accepted at the earliest in the cycle after o_done.
- o_dmem_addr and o_dmem_wdata are stable for the whole of RD/RD_WAIT and WR/WR_WAIT.
- Reset asserted in the same cycle as i_req: reset wins, and the request is dropped.

## Test plan

- LW addr 0x10, memory word 0x8765_4321, no stall → cen pulse in cycle 1 with o_dmem_addr=0x10; o_done in cycle 3 with o_rdata=0x8765_4321, o_err=0.
- LB addr 0x13, word 0x80FF_0000 → o_rdata=0xFFFF_FF80. LBU → 0x0000_0080. LH addr 0x12 → 0xFFFF_80FF. LHU → 0x0000_80FF.
- SB addr 0x21, i_wdata=0xAB, memory word 0x1122_3344, stall=1 for 2 cycles in RD_WAIT → write 0x1122_AB44 to 0x20; o_done in cycle 7.
- LW addr 0x02; SH addr 0x05; funct3=011 load; SB with funct3=100 → each gives o_done+o_err in cycle 1, no cen pulse, o_rdata unchanged.
- SH addr 0x22 with i_rst_n driven low during WR_WAIT → next cycle IDLE, all outputs 0. A fresh LW to the same word then returns the original, unmodified word.
- i_req toggled high during busy cycles of a load → ignored; exactly one o_done. Back-to-back requests with i_req held high → second accepted in the cycle after o_done.
